add_arbiter: RTL and testbench

Shares one 32-bit adder (the AddBeta-style datapath) among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. A round-robin arbiter grants one request at a time, and a three-state sequencer computes the sum and returns it with the winner's id on a single response channel. The block sits between the requesting control units and the shared adder, so no requester needs its own adder.

---
 rtl/add_arb_pkg.sv | 11 +
 rtl/add_arb_rr.sv | 33 +++
 rtl/add_arbiter.sv | 77 +++++++
 tb/tb_add_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared types and limits for the add_arbiter slice
// Holds the sequencer state encoding, the default datapath width and the requester limit.
package add_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;
  localparam int WIDTH_DEF = 32;
  localparam int NREQ_MAX = 16;
endpackage

// File: rtl/add_arb_rr.sv
// add_arb_rr: combinational round-robin picker
// Ports: req (request vector), ptr (highest-priority index), en (allow a grant)
//        gnt (one-hot grant), id (encoded winner), any (a grant is issued).
module add_arb_rr
  import add_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id,
  output logic            any
);
  int k;
  // Scan from the farthest offset back to the pointer so the last hit is the first in wrap order.
  always_comb begin
    gnt = '0;
    id = '0;
    k = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NREQ;
      if (en && req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        id = IDW'(k);
      end
    end
  end
  assign any = en && (|req);
endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sharing of one WIDTH-bit adder among NREQ requesters
// Ports: clock, reset_n (async active-low); req_valid/req_ready per requester;
//        req_in0/req_in1 operands packed at [i*WIDTH +: WIDTH];
//        rsp_valid/rsp_ready response handshake with rsp_id, rsp_data, rsp_carry.
// Option: define ADD_ARB_SAT_EN to saturate rsp_data to all-ones when the carry is set.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = WIDTH_DEF,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_in0,
  input  logic [NREQ*WIDTH-1:0] req_in1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_carry
);
  state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, win_id;
  logic [WIDTH-1:0] in0_q, in0_d, in1_q, in1_d;
  logic [WIDTH:0] res_q, res_d;
  logic [NREQ-1:0] win_gnt;
  logic win_any, pick_en;
  // Gating with reset_n keeps req_ready low while reset is held, even in IDLE.
  assign pick_en = (state_q == IDLE) && reset_n;
  add_arb_rr #(.NREQ(NREQ)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (pick_en),
    .gnt (win_gnt),
    .id  (win_id),
    .any (win_any)
  );
  assign req_ready = win_gnt;
  always_comb begin
    state_d = (state_q == IDLE) ? (win_any ? CALC : IDLE) :
              (state_q == CALC) ? RESP :
              (state_q == RESP && !rsp_ready) ? RESP : IDLE;
    ptr_d = win_any ? ((win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1)) : ptr_q;
    id_d = win_any ? win_id : id_q;
    in0_d = win_any ? req_in0[int'(win_id)*WIDTH +: WIDTH] : in0_q;
    in1_d = win_any ? req_in1[int'(win_id)*WIDTH +: WIDTH] : in1_q;
    res_d = (state_q == CALC) ? {1'b0, in0_q} + {1'b0, in1_q} : res_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      in0_q <= '0;
      in1_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      in0_q <= in0_d;
      in1_q <= in1_d;
      res_q <= res_d;
    end
  end
  assign rsp_valid = (state_q == RESP);
  assign rsp_id = id_q;
  assign rsp_carry = res_q[WIDTH];
`ifdef ADD_ARB_SAT_EN
  assign rsp_data = res_q[WIDTH] ? '1 : res_q[WIDTH-1:0];
`else
  assign rsp_data = res_q[WIDTH-1:0];
`endif
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: self-checking bench for add_arbiter against a transaction-level model
module tb_add_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_in0, req_in1;
  logic rsp_valid, rsp_ready, rsp_carry;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_data;
  logic [W-1:0] a_op [N];
  logic [W-1:0] b_op [N];
  int m_ptr, n_checks, n_errors;

  always #5 clock = ~clock;

  add_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in0   (req_in0),
    .req_in1   (req_in1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_in0[i*W +: W] = a_op[i];
      req_in1[i*W +: W] = b_op[i];
    end
  endtask

  // Winner: first valid requester at or after the pointer, wrapping.
  function automatic int pick(logic [N-1:0] m, int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  function automatic logic [W-1:0] exp_data(logic [W-1:0] a, logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef ADD_ARB_SAT_EN
    return s[W] ? {W{1'b1}} : s[W-1:0];
`else
    return s[W-1:0];
`endif
  endfunction

  function automatic logic exp_carry(logic [W-1:0] a, logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W];
  endfunction

  // One full operation from an IDLE cycle: grant, CALC, then RESP held for 'stall' extra cycles.
  task automatic run_op(input logic [N-1:0] mask, input int stall);
    int w;
    logic [N-1:0] eg;
    req_valid = mask;
    rsp_ready = 1'b0;
    pack();
    #1;
    w = pick(mask, m_ptr);
    eg = 4'(1) << w;
    n_checks++;
    if (req_ready !== eg) begin
      n_errors++;
      $display("FAIL grant: req_ready=%b expected %b", req_ready, eg);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== '0) begin
      n_errors++;
      $display("FAIL calc_idle: rsp_valid=%b req_ready=%b expected 0/0000", rsp_valid, req_ready);
    end
    step();
    for (int c = 0; c <= stall; c++) begin
      rsp_ready = (c == stall);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(w) || rsp_data !== exp_data(a_op[w], b_op[w]) ||
          rsp_carry !== exp_carry(a_op[w], b_op[w]) || req_ready !== '0) begin
        n_errors++;
        $display("FAIL resp: valid=%b id=%0d data=%h carry=%b ready=%b expected 1 %0d %h %b 0000",
                 rsp_valid, rsp_id, rsp_data, rsp_carry, req_ready, w,
                 exp_data(a_op[w], b_op[w]), exp_carry(a_op[w], b_op[w]));
      end
      step();
    end
    rsp_ready = 1'b0;
    m_ptr = (w + 1) % N;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_op[i] = 32'(i + 1);
      b_op[i] = 32'(10 * i);
    end
    pack();
    step();
    step();
    n_checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0 || rsp_carry !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: ready=%b valid=%b id=%0d data=%h carry=%b expected all zero",
               req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry);
    end
    req_valid = '0;
    reset_n = 1'b1;
    m_ptr = 0;
    step();
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 5; k++) run_op(4'b1111, 0);
  endtask

  task automatic test_single();
    a_op[2] = 32'h0000_00A0;
    b_op[2] = 32'h0000_0005;
    run_op(4'b0100, 0);
  endtask

  task automatic test_overflow();
    a_op[3] = 32'hFFFF_FFFF;
    b_op[3] = 32'h0000_0002;
    run_op(4'b1000, 0);
  endtask

  task automatic test_back_pressure();
    a_op[0] = 32'h1234_5678;
    b_op[0] = 32'h1111_1111;
    run_op(4'b1111, 10);
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1111;
    pack();
    step();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== '0) begin
      n_errors++;
      $display("FAIL reset_mid: rsp_valid=%b req_ready=%b expected 0/0000", rsp_valid, req_ready);
    end
    step();
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_hold: rsp_valid=%b expected 0", rsp_valid);
    end
    reset_n = 1'b1;
    m_ptr = 0;
    run_op(4'b1111, 0);
  endtask

  task automatic test_withdraw();
    int w;
    w = pick(4'b1000, m_ptr);
    req_valid = 4'b1000;
    pack();
    step();
    step();
    req_valid = 4'b0010;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'(w) || req_ready !== '0) begin
      n_errors++;
      $display("FAIL withdraw_resp: valid=%b id=%0d ready=%b expected 1 %0d 0000", rsp_valid, rsp_id, req_ready, w);
    end
    step();
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    m_ptr = (w + 1) % N;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (req_ready !== '0 || rsp_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL withdraw_idle: ready=%b valid=%b expected 0000/0", req_ready, rsp_valid);
      end
      step();
    end
    run_op(4'b1111, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < N; i++) begin
        a_op[i] = $urandom;
        b_op[i] = ($urandom_range(0, 3) == 0) ? ~a_op[i] + 32'($urandom_range(0, 2)) : $urandom;
      end
      run_op(4'($urandom_range(1, 15)), $urandom_range(0, 3));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_round_robin();
    test_single();
    test_overflow();
    test_back_pressure();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
